// File: rtl/hbm_edge_rd_arbiter_pkg.sv
// rtl/hbm_edge_rd_arbiter_pkg.sv - shared accelerator widths and arbiter types
//
// Purpose: the HBM edge-read widths shared across the accelerator.
// Also holds the requester-index width helper and the output FSM state type.
// No ports (package).
package hbm_edge_rd_arbiter_pkg;

  localparam int HBM_AWIDTH    = 28;
  localparam int HBM_EDGE_MASK = 8;
  localparam int V_ID_WIDTH    = 32;
  localparam int ARB_REQ_NUM   = 4;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_IDX_W = idx_width(ARB_REQ_NUM);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/hbm_edge_rd_arbiter_fifo.sv
// rtl/hbm_edge_rd_arbiter_fifo.sv - per-requester FWFT buffer with prog_full and sticky overflow
//
// Module arb_req_fifo
//   clk, rst     : clock, synchronous active-high reset
//   wr_en        : push wr_data (dropped and flagged when completely full)
//   rd_en        : pop the head entry (ignored when empty)
//   rd_data      : head entry, valid whenever empty is low
//   empty        : no entries stored
//   prog_full    : registered, high while occupancy >= DEPTH-PF_MARGIN
//   overflow     : sticky, set by a write to a completely full buffer
module arb_req_fifo #(
  parameter int DEPTH     = 16,
  parameter int PF_MARGIN = 4,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             prog_full,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] PF_CNT   = CW'(DEPTH - PF_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_wr;
  logic             do_rd;

  // A write to a full buffer is dropped even if a pop happens in the same
  // cycle; the full check uses the occupancy before this cycle's pop.
  assign do_wr = wr_en && (count != FULL_CNT);
  assign do_rd = rd_en && (count != '0);

  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      prog_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      prog_full <= (count_nxt >= PF_CNT);
      if (wr_en && (count == FULL_CNT)) overflow <= 1'b1;
    end
  end

  // Storage has no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

endmodule

// File: rtl/hbm_edge_rd_arbiter.sv
// rtl/hbm_edge_rd_arbiter.sv - round-robin arbiter of edge-read requesters onto one HBM read port
//
// Optional feature macro: ARB_PERF_CNT_EN (adds grant_cnt / stall_cnt).
//   clk, rst                       : clock, synchronous active-high reset
//   req_addr/req_mask/req_v_id     : per-requester request fields, flattened
//   req_valid                      : per-requester write strobe
//   req_full                       : per-requester programmable-full backpressure
//   hbm_araddr/armask/arvid/artag  : granted request, artag = requester index
//   hbm_arvalid, hbm_arready       : valid/ready handshake towards HBM
//   all_idle                       : all buffers empty and no request pending
//   overflow                       : sticky per-requester write-while-full flags
//   grant_cnt, stall_cnt           : saturating perf counters (ARB_PERF_CNT_EN only)
module hbm_edge_rd_arbiter #(
  parameter int REQ_NUM       = hbm_edge_rd_arbiter_pkg::ARB_REQ_NUM,
  parameter int FIFO_DEPTH    = 16,
  parameter int PF_MARGIN     = 4,
  parameter int HBM_AWIDTH    = hbm_edge_rd_arbiter_pkg::HBM_AWIDTH,
  parameter int HBM_EDGE_MASK = hbm_edge_rd_arbiter_pkg::HBM_EDGE_MASK,
  parameter int V_ID_WIDTH    = hbm_edge_rd_arbiter_pkg::V_ID_WIDTH
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [REQ_NUM*HBM_AWIDTH-1:0]                     req_addr,
  input  logic [REQ_NUM*HBM_EDGE_MASK-1:0]                  req_mask,
  input  logic [REQ_NUM*V_ID_WIDTH-1:0]                     req_v_id,
  input  logic [REQ_NUM-1:0]                                req_valid,
  output logic [REQ_NUM-1:0]                                req_full,
  output logic [HBM_AWIDTH-1:0]                             hbm_araddr,
  output logic [HBM_EDGE_MASK-1:0]                          hbm_armask,
  output logic [V_ID_WIDTH-1:0]                             hbm_arvid,
  output logic [hbm_edge_rd_arbiter_pkg::idx_width(REQ_NUM)-1:0] hbm_artag,
  output logic                                              hbm_arvalid,
  input  logic                                              hbm_arready,
  output logic                                              all_idle,
  output logic [REQ_NUM-1:0]                                overflow
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [REQ_NUM*32-1:0]                             grant_cnt,
  output logic [31:0]                                       stall_cnt
`endif
);

  import hbm_edge_rd_arbiter_pkg::*;

  localparam int TAG_W = idx_width(REQ_NUM);
  localparam int EW    = HBM_AWIDTH + HBM_EDGE_MASK + V_ID_WIDTH;

  logic [REQ_NUM-1:0] fifo_empty;
  logic [REQ_NUM-1:0] fifo_pop;
  logic [EW-1:0]      fifo_dout [REQ_NUM];

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_req
    arb_req_fifo #(
      .DEPTH     (FIFO_DEPTH),
      .PF_MARGIN (PF_MARGIN),
      .WIDTH     (EW)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (req_valid[g]),
      .wr_data   ({req_v_id[g*V_ID_WIDTH +: V_ID_WIDTH],
                   req_mask[g*HBM_EDGE_MASK +: HBM_EDGE_MASK],
                   req_addr[g*HBM_AWIDTH +: HBM_AWIDTH]}),
      .rd_en     (fifo_pop[g]),
      .rd_data   (fifo_dout[g]),
      .empty     (fifo_empty[g]),
      .prog_full (req_full[g]),
      .overflow  (overflow[g])
    );
  end

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [TAG_W-1:0] last_grant;
  logic [TAG_W-1:0] sel;
  logic             any_req;
  logic             load;

  assign any_req = |(~fifo_empty);

  // Round-robin pick: first non-empty requester after last_grant, wrapping.
  always_comb begin
    int               idx;
    logic [TAG_W-1:0] idx_t;
    logic             found;
    sel   = '0;
    idx   = 0;
    idx_t = '0;
    found = 1'b0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      idx   = (int'(last_grant) + k) % REQ_NUM;
      idx_t = TAG_W'(idx);
      if (!found && !fifo_empty[idx_t]) begin
        sel   = idx_t;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // The output register may be refilled whenever it is empty or being
  // accepted this cycle; a stalled request keeps the state in SEND.
  always_comb begin
    load      = 1'b0;
    state_nxt = ST_EMPTY;
    fifo_pop  = '0;
    if (((state == ST_EMPTY) || hbm_arready) && any_req) load = 1'b1;
    if (load) begin
      state_nxt     = ST_SEND;
      fifo_pop[sel] = 1'b1;
    end else if ((state == ST_SEND) && !hbm_arready) begin
      state_nxt = ST_SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hbm_araddr <= '0;
      hbm_armask <= '0;
      hbm_arvid  <= '0;
      hbm_artag  <= '0;
      last_grant <= TAG_W'(REQ_NUM - 1);
    end else if (load) begin
      {hbm_arvid, hbm_armask, hbm_araddr} <= fifo_dout[sel];
      hbm_artag  <= sel;
      last_grant <= sel;
    end
  end

  assign hbm_arvalid = (state == ST_SEND);
  assign all_idle    = (&fifo_empty) && (state == ST_EMPTY);

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (hbm_arvalid && hbm_arready && (hbm_artag == TAG_W'(i)) &&
            (grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF))
          grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
      end
      if (hbm_arvalid && !hbm_arready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hbm_edge_rd_arbiter.sv
// tb/tb_hbm_edge_rd_arbiter.sv - self-checking bench for hbm_edge_rd_arbiter
module tb_hbm_edge_rd_arbiter;
  import hbm_edge_rd_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int PFM   = 4;
  localparam int AW    = HBM_AWIDTH;
  localparam int MW    = HBM_EDGE_MASK;
  localparam int VW    = V_ID_WIDTH;
  localparam int TW    = REQ_IDX_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] req_addr;
  logic [N*MW-1:0] req_mask;
  logic [N*VW-1:0] req_v_id;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_full;
  logic [AW-1:0]   hbm_araddr;
  logic [MW-1:0]   hbm_armask;
  logic [VW-1:0]   hbm_arvid;
  logic [TW-1:0]   hbm_artag;
  logic            hbm_arvalid;
  logic            hbm_arready;
  logic            all_idle;
  logic [N-1:0]    overflow;
`ifdef ARB_PERF_CNT_EN
  logic [N*32-1:0] grant_cnt;
  logic [31:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  hbm_edge_rd_arbiter #(
    .REQ_NUM(N), .FIFO_DEPTH(DEPTH), .PF_MARGIN(PFM)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_mask(req_mask), .req_v_id(req_v_id),
    .req_valid(req_valid), .req_full(req_full),
    .hbm_araddr(hbm_araddr), .hbm_armask(hbm_armask), .hbm_arvid(hbm_arvid),
    .hbm_artag(hbm_artag), .hbm_arvalid(hbm_arvalid), .hbm_arready(hbm_arready),
    .all_idle(all_idle), .overflow(overflow)
`ifdef ARB_PERF_CNT_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: one queue per requester plus a single output slot.
  typedef struct {
    logic [AW-1:0] a;
    logic [MW-1:0] m;
    logic [VW-1:0] v;
  } ent_t;

  ent_t         mq [N][$];
  logic         m_valid;
  int           m_tag;
  ent_t         m_out;
  int           m_last;
  logic [N-1:0] m_ovf;

  task automatic model_clock();
    int   sizes [N];
    bit   any;
    int   j;
    ent_t e;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_valid = 1'b0;
      m_tag   = 0;
      m_last  = N - 1;
      m_ovf   = '0;
      return;
    end
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      sizes[i] = mq[i].size();
      if (sizes[i] > 0) any = 1'b1;
    end
    if ((!m_valid || hbm_arready) && any) begin
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (mq[j].size() > 0) break;
      end
      m_out   = mq[j].pop_front();
      m_tag   = j;
      m_last  = j;
      m_valid = 1'b1;
    end else if (m_valid && hbm_arready) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        if (sizes[i] == DEPTH) m_ovf[i] = 1'b1;
        else begin
          e.a = req_addr[i*AW +: AW];
          e.m = req_mask[i*MW +: MW];
          e.v = req_v_id[i*VW +: VW];
          mq[i].push_back(e);
        end
      end
    end
  endtask

  task automatic model_check();
    logic [N-1:0] exp_full;
    logic         exp_idle;
    exp_idle = !m_valid;
    for (int i = 0; i < N; i++) begin
      exp_full[i] = (mq[i].size() >= DEPTH - PFM);
      if (mq[i].size() != 0) exp_idle = 1'b0;
    end
    check("m_arvalid", hbm_arvalid, m_valid);
    if (m_valid) begin
      check("m_artag", hbm_artag, m_tag);
      check("m_araddr", hbm_araddr, m_out.a);
      check("m_armask", hbm_armask, m_out.m);
      check("m_arvid", hbm_arvid, m_out.v);
    end
    check("m_req_full", req_full, exp_full);
    check("m_overflow", overflow, m_ovf);
    check("m_all_idle", all_idle, exp_idle);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    model_check();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [MW-1:0] m,
                         input logic [VW-1:0] v);
    req_addr[i*AW +: AW] = a;
    req_mask[i*MW +: MW] = m;
    req_v_id[i*VW +: VW] = v;
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic          rdy;
    logic          exp_valid;
    logic [TW-1:0] exp_tag;
    logic [AW-1:0] exp_addr;
    logic          exp_idle;
  } vec_t;

  vec_t tbl [4];

  initial begin
    tbl[0] = '{4'b0100, 1'b1, 1'b0, 2'd0, 28'h0,  1'b0};
    tbl[1] = '{4'b0000, 1'b1, 1'b1, 2'd2, 28'h40, 1'b0};
    tbl[2] = '{4'b0000, 1'b1, 1'b0, 2'd0, 28'h0,  1'b1};
    tbl[3] = '{4'b0000, 1'b0, 1'b0, 2'd0, 28'h0,  1'b1};

    rst = 1'b1; req_valid = '0; req_addr = '0; req_mask = '0; req_v_id = '0;
    hbm_arready = 1'b0;
    step(); step();
    check("rst_arvalid", hbm_arvalid, 0);
    check("rst_araddr", hbm_araddr, 0);
    check("rst_armask", hbm_armask, 0);
    check("rst_arvid", hbm_arvid, 0);
    check("rst_artag", hbm_artag, 0);
    check("rst_req_full", req_full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_all_idle", all_idle, 1);
    rst = 1'b0;

    // Single request on requester 2 with arready held high.
    set_req(2, 28'h40, 8'hFF, 32'h7);
    for (int k = 0; k < 4; k++) begin
      req_valid   = tbl[k].valid;
      hbm_arready = tbl[k].rdy;
      step();
      check($sformatf("tbl%0d_arvalid", k), hbm_arvalid, tbl[k].exp_valid);
      if (tbl[k].exp_valid) begin
        check($sformatf("tbl%0d_artag", k), hbm_artag, tbl[k].exp_tag);
        check($sformatf("tbl%0d_araddr", k), hbm_araddr, tbl[k].exp_addr);
      end
      check($sformatf("tbl%0d_all_idle", k), all_idle, tbl[k].exp_idle);
    end
    req_valid = '0;

    // Round-robin across four requesters holding three entries each.
    rst = 1'b1; step(); rst = 1'b0;
    hbm_arready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) set_req(i, AW'(i*16 + r), MW'(i + 1), VW'(r));
      req_valid = '1;
      step();
    end
    req_valid   = '0;
    hbm_arready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("rr_arvalid", hbm_arvalid, 1);
      check("rr_artag", hbm_artag, k % 4);
      check("rr_araddr", hbm_araddr, (k % 4) * 16 + k / 4);
      step();
    end
    check("rr_end_arvalid", hbm_arvalid, 0);
    check("rr_end_idle", all_idle, 1);

    // Five-cycle stall: outputs hold and the second entry stays buffered.
    rst = 1'b1; step(); rst = 1'b0;
    hbm_arready = 1'b0;
    set_req(3, 28'h100, 8'h0F, 32'h33); req_valid = 4'b1000; step();
    set_req(3, 28'h200, 8'hF0, 32'h44); step();
    req_valid = '0;
    check("st_arvalid0", hbm_arvalid, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("st_arvalid", hbm_arvalid, 1);
      check("st_araddr", hbm_araddr, 28'h100);
      check("st_armask", hbm_armask, 8'h0F);
      check("st_arvid", hbm_arvid, 32'h33);
      check("st_artag", hbm_artag, 3);
      check("st_idle", all_idle, 0);
    end
`ifdef ARB_PERF_CNT_EN
    check("st_stall_cnt", stall_cnt, 5);
`endif
    hbm_arready = 1'b1;
    step();
    check("st_next_valid", hbm_arvalid, 1);
    check("st_next_addr", hbm_araddr, 28'h200);
    step();
    check("st_done_valid", hbm_arvalid, 0);
    check("st_done_idle", all_idle, 1);

    // Fill requester 1 past prog_full and into overflow while port is stalled.
    rst = 1'b1; step(); rst = 1'b0;
    hbm_arready = 1'b0;
    set_req(0, 28'h1, 8'h1, 32'h1); req_valid = 4'b0001; step();
    req_valid = 4'b0010;
    for (int k = 1; k <= 17; k++) begin
      set_req(1, AW'(k), MW'(k), VW'(k));
      step();
      if (k == 11) check("pf_before", req_full[1], 0);
      if (k == 12) check("pf_after", req_full[1], 1);
      if (k == 16) check("ovf_before", overflow[1], 0);
      if (k == 17) check("ovf_after", overflow[1], 1);
    end
    req_valid = '0;

    // Reset mid-operation discards everything; requester 0 wins first.
    rst = 1'b1; step(); rst = 1'b0;
    check("mr_arvalid", hbm_arvalid, 0);
    check("mr_idle", all_idle, 1);
    check("mr_full", req_full, 0);
    check("mr_ovf", overflow, 0);
    set_req(0, 28'hA0, 8'h3, 32'h10);
    set_req(2, 28'hA2, 8'h5, 32'h12);
    req_valid = 4'b0101; hbm_arready = 1'b1; step();
    req_valid = '0; step();
    check("mr_first_valid", hbm_arvalid, 1);
    check("mr_first_tag", hbm_artag, 0);
    check("mr_first_addr", hbm_araddr, 28'hA0);
    step();
    check("mr_second_tag", hbm_artag, 2);

    // Randomized traffic with occasional mid-stream reset.
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        set_req(i, AW'($urandom), MW'($urandom), VW'($urandom));
        req_valid[i] = ($urandom_range(0, 2) == 0) && !req_full[i];
      end
      hbm_arready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hbm_edge_rd_arbiter.md
HBM_EDGE_RD_ARBITER -- requirements
Module: hbm_edge_rd_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, 4, number of edge-read requesters sharing one HBM read port.
REQ-002 SHALL have parameter FIFO_DEPTH, 16, entries per requester buffer (power of 2).
REQ-003 SHALL have parameter PF_MARGIN, 4, free entries left when req_full asserts.
REQ-004 SHALL have parameters HBM_AWIDTH, HBM_EDGE_MASK, V_ID_WIDTH, defaulting to the shared accelerator widths.
REQ-005 SHALL have clk  in  1  clock.
REQ-006 SHALL have rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have req_addr  in  REQ_NUM*HBM_AWIDTH  cacheline address per requester.
REQ-008 SHALL have req_mask  in  REQ_NUM*HBM_EDGE_MASK  edge-slot mask per requester.
REQ-009 SHALL have req_v_id  in  REQ_NUM*V_ID_WIDTH  source vertex id per requester.
REQ-010 SHALL have req_valid  in  REQ_NUM  write strobe per requester.
REQ-011 SHALL have req_full  out  REQ_NUM  programmable-full backpressure per requester.
REQ-012 SHALL have hbm_araddr / hbm_armask / hbm_arvid  out  HBM_AWIDTH / HBM_EDGE_MASK / V_ID_WIDTH  granted request.
REQ-013 SHALL have hbm_artag  out  clog2(REQ_NUM)  index of granted requester.
REQ-014 SHALL have hbm_arvalid  out  1, and hbm_arready  in  1  (valid/ready handshake).
REQ-015 SHALL have all_idle  out  1  high when all buffers are empty and hbm_arvalid is low.
REQ-016 SHALL have overflow  out  REQ_NUM  sticky write-while-full error flags.

Function
REQ-017 SHALL buffer each requester in its own first-word-fall-through FIFO; a write occurs when req_valid[i]=1.
REQ-018 SHALL assert req_full[i] when occupancy >= FIFO_DEPTH-PF_MARGIN, registered, and deassert it when occupancy falls below that threshold.
REQ-019 SHALL drop a write to a completely full FIFO and set overflow[i] until reset.
REQ-020 SHALL use a 2-state output FSM: EMPTY (hbm_arvalid=0) and SEND (hbm_arvalid=1).
REQ-021 SHALL load the output register when state is EMPTY, or when state is SEND and hbm_arready=1, provided at least one FIFO is non-empty; the next state is SEND, otherwise EMPTY.
REQ-022 SHALL select the requester round-robin: first non-empty index searching from last_grant+1 modulo REQ_NUM; last_grant updates only on a load.
REQ-023 SHALL pop exactly the selected FIFO in the load cycle; a simultaneous push and pop on the same FIFO SHALL keep occupancy unchanged.
REQ-024 SHALL hold all hbm_ar* outputs stable while hbm_arvalid=1 and hbm_arready=0.
REQ-025 SHALL sustain one grant per cycle when hbm_arready stays high; minimum latency from req_valid to hbm_arvalid is 2 cycles.
REQ-026 SHALL drive all_idle combinationally from registered state only, so it has no combinational path from req_valid.

Reset
REQ-027 SHALL on rst empty all FIFOs and clear: hbm_arvalid=0, hbm_araddr/armask/arvid/artag=0, req_full=0, overflow=0, all_idle=1, and state EMPTY.
REQ-028 SHALL set last_grant=REQ_NUM-1 on reset, so that requester 0 wins first.
REQ-029 SHALL discard any pending or unaccepted request when rst asserts mid-operation, with no handshake completed.

Configuration
REQ-030 SHALL, with ARB_PERF_CNT_EN defined, add output grant_cnt (REQ_NUM*32), which counts accepted handshakes per requester, and output stall_cnt (32), which counts cycles with hbm_arvalid=1 and hbm_arready=0; both SHALL saturate at 2^32-1 and clear on rst.
REQ-031 SHALL, without ARB_PERF_CNT_EN, omit these ports and counters entirely; function is otherwise identical.

Structure
REQ-032 SHALL take HBM_AWIDTH, HBM_EDGE_MASK and V_ID_WIDTH from the shared accelerator header/package; REQ_IDX_W=clog2(REQ_NUM) belongs in the same package.
REQ-033 SHALL implement the per-requester buffer as sub-module arb_req_fifo (FWFT, prog_full, overflow), instantiated REQ_NUM times by generate.

Verification
REQ-034 SHALL cover: single write on requester 2 (addr 0x40, mask 0xFF) at cycle t with arready=1 -> hbm_arvalid at t+2, artag=2, then all_idle=1.
REQ-035 SHALL cover: all 4 requesters hold 3 entries each, arready=1 -> artag sequence 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles.
REQ-036 SHALL cover: arready=0 for 5 cycles while arvalid=1 -> outputs unchanged, no pop occurs, and stall_cnt=5 when ARB_PERF_CNT_EN is defined.
REQ-037 SHALL cover: 12 writes to requester 1 with arready=0 -> req_full[1] rises after the 12th write; 5 further writes -> the 17th write is dropped and overflow[1]=1.
REQ-038 SHALL cover: rst asserted while arvalid=1 and FIFOs hold entries -> the next cycle shows arvalid=0, all_idle=1, the first grant after reset goes to requester 0.
